// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: the state encoding (also read
// by debug/ILA taps through state_dbg) and counter sizing.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_REQ       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;

    // Width of a counter holding 0..limit-1, never narrower than one bit.
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_sync2.sv
// Generic two-flop synchronizer for slow level signals crossing into the local clock.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/rst_sequencer.sv
// Lock supervisor for the two-DCM chain: qualifies stable lock, releases the
// downstream resets one stage at a time, and escalates to a DCM re-reset or fault.
//
// state        | meaning
// WAIT_LOCK    | resets held, waiting for both DCMs locked, timeout running
// HOLD         | lock seen, counting consecutive locked cycles
// RELEASE      | releasing stage k when the gap counter reaches k*STAGE_GAP
// RUN          | all stages released, ready high
// REQ          | dcm_rst_req pulse of REQ_CYCLES, lock ignored
// FAULT        | lock never achieved within retry budget; only rst_in leaves
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int REQ_CYCLES     = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            locked_in,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  dcm_rst_req,
    output logic                  ready,
    output logic                  fault,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic [2:0]            state_dbg
);
    localparam int GAP_SPAN = (NUM_STAGES - 1) * STAGE_GAP;
    localparam int TO_W     = cnt_w(TIMEOUT_CYCLES);
    localparam int HOLD_W   = cnt_w(HOLD_CYCLES);
    localparam int GAP_W    = cnt_w(GAP_SPAN + 1);
    localparam int REQ_W    = cnt_w(REQ_CYCLES);
    localparam int RETRY_W  = cnt_w(MAX_RETRIES);

    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_SPAN);
    localparam logic [REQ_W-1:0]   REQ_LAST   = REQ_W'(REQ_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

    seq_state_t            state;
    logic [1:0]            locked_sync;
    logic                  lk;
    logic [TO_W-1:0]       to_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [REQ_W-1:0]      req_cnt;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [NUM_STAGES-1:0] rel_mask;

    sync2 #(.WIDTH(2)) u_lock_sync (
        .clk (clk_in),
        .rst (rst_in),
        .d   (locked_in),
        .q   (locked_sync)
    );

    assign lk        = &locked_sync;
    assign state_dbg = state;

    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (gap_cnt == GAP_W'(k * STAGE_GAP)) rel_mask[k] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_WAIT_LOCK;
            rst_out     <= '1;
            dcm_rst_req <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            loss_cnt    <= '0;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            req_cnt     <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    // Resets re-assert here, one cycle after a lock loss is seen.
                    rst_out <= '1;
                    if (lk) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        retry_cnt <= '0;
                        to_cnt    <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt <= '0;
                        if (retry_cnt == RETRY_LAST) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end else begin
                            retry_cnt   <= retry_cnt + 1'b1;
                            state       <= ST_REQ;
                            req_cnt     <= '0;
                            dcm_rst_req <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!lk) begin
                        state  <= ST_WAIT_LOCK;
                        to_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state   <= ST_RELEASE;
                        gap_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (!lk) begin
                        state     <= ST_WAIT_LOCK;
                        ready     <= 1'b0;
                        to_cnt    <= '0;
                        hold_cnt  <= '0;
                        gap_cnt   <= '0;
                        retry_cnt <= '0;
                        if (loss_cnt != {LOSS_CNT_W{1'b1}}) loss_cnt <= loss_cnt + 1'b1;
                    end else if (state == ST_RELEASE) begin
                        rst_out <= rst_out & ~rel_mask;
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (req_cnt == REQ_LAST) begin
                        state       <= ST_WAIT_LOCK;
                        dcm_rst_req <= 1'b0;
                        to_cnt      <= '0;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    rst_out <= '1;
                    fault   <= 1'b1;
                end
                default: begin
                    state   <= ST_WAIT_LOCK;
                    rst_out <= '1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random lock patterns checked
// against a timestamp-based reference of the lock/release/retry rules.
module tb_rst_sequencer;
    localparam int N = 3, HOLD = 8, GAP = 4, TMO = 32, REQ = 5, RETRIES = 3;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [1:0]   locked_in;
    logic [N-1:0] rst_out;
    logic         dcm_rst_req, ready, fault;
    logic [7:0]   loss_cnt;
    logic [2:0]   state_dbg;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_STAGES(N), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
        .TIMEOUT_CYCLES(TMO), .REQ_CYCLES(REQ), .MAX_RETRIES(RETRIES)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .locked_in(locked_in), .rst_out(rst_out),
        .dcm_rst_req(dcm_rst_req), .ready(ready), .fault(fault),
        .loss_cnt(loss_cnt), .state_dbg(state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: phases with the edge number at which each was entered.
    typedef enum int {M_WAIT, M_HOLD, M_LIVE, M_REQ, M_FAULT} mode_t;
    mode_t        m_mode;
    int           m_t0, m_h, m_r, m_q, m_tries, m_loss;
    bit           m_d1, m_d2;
    logic [N-1:0] m_rst;
    logic [2:0]   exp_state;
    logic         exp_ready, exp_req, exp_fault;

    task automatic model_reset();
        m_mode = M_WAIT; m_t0 = 0; m_tries = 0; m_loss = 0;
        m_d1 = 0; m_d2 = 0; m_rst = '1;
        exp_state = 3'd0; exp_ready = 0; exp_req = 0; exp_fault = 0;
    endtask

    task automatic model_step(input bit lk, input int e);
        bit lost = 0;
        bit all_out;
        case (m_mode)
            M_WAIT:
                if (lk) begin m_mode = M_HOLD; m_h = e; m_tries = 0; end
                else if (e - m_t0 == TMO) begin
                    if (m_tries + 1 == RETRIES) m_mode = M_FAULT;
                    else begin m_tries++; m_mode = M_REQ; m_q = e; end
                end
            M_HOLD:
                if (!lk) begin m_mode = M_WAIT; m_t0 = e; end
                else if (e - m_h == HOLD) begin m_mode = M_LIVE; m_r = e; end
            M_LIVE:
                if (!lk) begin
                    m_mode = M_WAIT; m_t0 = e; m_tries = 0; lost = 1;
                    if (m_loss < 255) m_loss++;
                end
            M_REQ:
                if (e - m_q == REQ) begin m_mode = M_WAIT; m_t0 = e; end
            default: ;
        endcase
        all_out = (m_mode == M_LIVE) && (e >= m_r + 1 + (N - 1) * GAP);
        if (m_mode == M_LIVE) begin
            for (int k = 0; k < N; k++) m_rst[k] = !(e >= m_r + 1 + k * GAP);
        end else if (!lost) begin
            m_rst = '1;
        end
        exp_ready = all_out;
        exp_req   = (m_mode == M_REQ);
        exp_fault = (m_mode == M_FAULT);
        case (m_mode)
            M_WAIT:  exp_state = 3'd0;
            M_HOLD:  exp_state = 3'd1;
            M_LIVE:  exp_state = all_out ? 3'd3 : 3'd2;
            M_REQ:   exp_state = 3'd4;
            default: exp_state = 3'd5;
        endcase
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic tick(input logic [1:0] v);
        bit lk_now;
        locked_in = v;
        @(posedge clk);
        cyc++;
        lk_now = m_d2; m_d2 = m_d1; m_d1 = (v == 2'b11);
        model_step(lk_now, cyc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_in = 1'b1; locked_in = 2'b00;
        @(posedge clk); @(negedge clk);
        rst_in = 1'b0; model_reset(); cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 1; c <= 15; c++) tick(2'b11);
        do_reset();
        n_tests++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL reset_rst_out got %b want 111", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
        n_tests++; if (dcm_rst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dcm_rst_req); end
        n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss got %0d want 0", loss_cnt); end
        n_tests++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    endtask

    task automatic test_clean_lock();
        int rel_at[N];
        int ready_at = 0;
        int want[N] = '{21, 25, 29};
        do_reset();
        for (int k = 0; k < N; k++) rel_at[k] = 0;
        for (int c = 1; c <= 34; c++) begin
            tick(c >= 10 ? 2'b11 : 2'b00);
            for (int k = 0; k < N; k++) if (rst_out[k] === 1'b0 && rel_at[k] == 0) rel_at[k] = c;
            if (ready === 1'b1 && ready_at == 0) ready_at = c;
        end
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (rel_at[k] != want[k]) begin
                n_fail++; $display("FAIL clean_stage%0d released at %0d want %0d", k, rel_at[k], want[k]);
            end
        end
        n_tests++; if (ready_at != 29) begin n_fail++; $display("FAIL clean_ready at %0d want 29", ready_at); end
        n_tests++; if (state_dbg !== 3'd3) begin n_fail++; $display("FAIL clean_run_state got %0d want 3", state_dbg); end
    endtask

    task automatic test_partial_lock();
        int req_first = 0, req_len = 0, released = 0;
        do_reset();
        for (int c = 1; c <= 45; c++) begin
            tick(2'b01);
            if (state_dbg === 3'd4 && req_first == 0) req_first = c;
            if (dcm_rst_req === 1'b1) req_len++;
            if (rst_out !== 3'b111) released++;
        end
        n_tests++; if (req_first != 32) begin n_fail++; $display("FAIL partial_req_entry at %0d want 32", req_first); end
        n_tests++; if (req_len != REQ) begin n_fail++; $display("FAIL partial_req_len got %0d want %0d", req_len, REQ); end
        n_tests++; if (released != 0) begin n_fail++; $display("FAIL partial_release got %0d cycles want 0", released); end
    endtask

    task automatic test_retry_fault();
        int pulses = 0, fault_at = 0;
        logic req_d = 1'b0;
        do_reset();
        for (int c = 1; c <= 140; c++) begin
            tick(2'b00);
            if (dcm_rst_req === 1'b1 && req_d === 1'b0) pulses++;
            req_d = dcm_rst_req;
            if (fault === 1'b1 && fault_at == 0) fault_at = c;
        end
        n_tests++; if (pulses != RETRIES - 1) begin n_fail++; $display("FAIL retry_pulses got %0d want %0d", pulses, RETRIES - 1); end
        n_tests++; if (fault_at != 106) begin n_fail++; $display("FAIL retry_fault_at got %0d want 106", fault_at); end
        n_tests++; if (state_dbg !== 3'd5) begin n_fail++; $display("FAIL retry_state got %0d want 5", state_dbg); end
        for (int c = 1; c <= 20; c++) tick(2'b11);
        n_tests++; if (fault !== 1'b1 || rst_out !== 3'b111) begin n_fail++; $display("FAIL fault_sticky got fault=%b rst=%b want 1/111", fault, rst_out); end
        do_reset();
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear got %b want 0", fault); end
    endtask

    task automatic test_glitch_hold();
        int rel0 = 0;
        bit saw_wait = 0;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick((c >= 10 && c != 15) ? 2'b11 : 2'b00);
            if (c == 17 && state_dbg === 3'd0) saw_wait = 1;
            if (rst_out[0] === 1'b0 && rel0 == 0) rel0 = c;
        end
        n_tests++; if (!saw_wait) begin n_fail++; $display("FAIL glitch_wait state at 17 got %0d want 0", state_dbg); end
        n_tests++; if (rel0 != 27) begin n_fail++; $display("FAIL glitch_release at %0d want 27", rel0); end
        n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_loss got %0d want 0", loss_cnt); end
    endtask

    task automatic test_loss_run();
        do_reset();
        for (int c = 1; c <= 30; c++) tick(2'b11);
        tick(2'b00);  // cycle 31
        tick(2'b00);
        tick(2'b00);  // cycle 33: loss seen, resets not yet back
        n_tests++; if (rst_out !== 3'b000) begin n_fail++; $display("FAIL loss_early_rst got %b want 000", rst_out); end
        tick(2'b00);  // cycle 34
        n_tests++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL loss_rst got %b want 111", rst_out); end
        n_tests++; if (loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt got %0d want 1", loss_cnt); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready got %b want 0", ready); end
        for (int c = 1; c <= 25; c++) tick(2'b11);
        n_tests++; if (ready !== 1'b1 || rst_out !== 3'b000) begin n_fail++; $display("FAIL relock got ready=%b rst=%b want 1/000", ready, rst_out); end
        for (int i = 0; i < 300; i++) begin
            tick(2'b00);
            for (int c = 1; c <= 14; c++) tick(2'b11);
            n_tests++;
            if (loss_cnt !== 8'(m_loss)) begin n_fail++; $display("FAIL loss_iter%0d got %0d want %0d", i, loss_cnt, m_loss); end
        end
        n_tests++; if (loss_cnt !== 8'd255) begin n_fail++; $display("FAIL loss_saturate got %0d want 255", loss_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 1; c <= 33; c++) begin
            tick(c >= 30 ? 2'b11 : 2'b00);
            if (c == 32) begin
                n_tests++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL tmo_edge_state got %0d want 1", state_dbg); end
                n_tests++; if (dcm_rst_req !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_req got %b want 0", dcm_rst_req); end
            end
        end
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            tick(c >= 14 ? 2'b00 : 2'b11);
            if (c == 16) begin
                n_tests++; if (rst_out !== 3'b110) begin n_fail++; $display("FAIL loss_vs_release got %b want 110", rst_out); end
                n_tests++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL loss_vs_release_state got %0d want 0", state_dbg); end
            end
        end
        n_tests++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL loss_vs_release_after got %b want 111", rst_out); end
    endtask

    task automatic test_reset_in_release();
        do_reset();
        for (int c = 1; c <= 13; c++) tick(2'b11);
        n_tests++; if (rst_out !== 3'b110) begin n_fail++; $display("FAIL rstrel_pre got %b want 110", rst_out); end
        rst_in = 1'b1;
        @(posedge clk); @(negedge clk);
        n_tests++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL rstrel_rst got %b want 111", rst_out); end
        n_tests++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rstrel_state got %0d want 0", state_dbg); end
        rst_in = 1'b0; model_reset(); cyc = 0;
    endtask

    task automatic test_random();
        logic [1:0] v;
        int len, total = 0;
        do_reset();
        while (total < 3000) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            v   = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
            len = (v == 2'b11) ? $urandom_range(1, 45) : $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                tick(v);
                total++;
                n_tests++;
                if (rst_out !== m_rst || ready !== exp_ready || dcm_rst_req !== exp_req ||
                    fault !== exp_fault || loss_cnt !== 8'(m_loss) || state_dbg !== exp_state) begin
                    n_fail++;
                    $display("FAIL random cyc %0d got rst=%b rdy=%b req=%b flt=%b loss=%0d st=%0d want rst=%b rdy=%b req=%b flt=%b loss=%0d st=%0d",
                             cyc, rst_out, ready, dcm_rst_req, fault, loss_cnt, state_dbg,
                             m_rst, exp_ready, exp_req, exp_fault, m_loss, exp_state);
                end
            end
        end
    endtask

    initial begin
        rst_in = 1'b1;
        locked_in = 2'b00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_clean_lock();
        test_partial_lock();
        test_retry_fault();
        test_glitch_hold();
        test_loss_run();
        test_simultaneous();
        test_reset_in_release();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Lock supervisor and staged reset sequencer for the two-DCM clock chain. Runs on the free-running board clock. Takes the DCM lock indicators, qualifies stable lock, and releases resets to downstream QAM blocks one stage at a time. On lock loss it re-asserts every reset at once. If lock never arrives, it requests a generator re-reset and stops in a sticky fault after repeated failures.

## Interface
Parameters:
- NUM_STAGES, 3: number of staged reset outputs (1–8).
- HOLD_CYCLES, 1024: consecutive qualified-lock cycles required before release starts.
- STAGE_GAP, 16: cycles between successive stage releases.
- TIMEOUT_CYCLES, 65536: wait-for-lock budget before a re-reset request.
- REQ_CYCLES, 64: width of the dcm_rst_req pulse.
- MAX_RETRIES, 3: consecutive timeouts tolerated before FAULT.

Ports:
- clk_in, input, 1: board clock; sole clock.
- rst_in, input, 1: synchronous, active-high reset.
- locked_in, input, 2: DCM lock bits {dcm1, dcm0}; asynchronous.
- rst_out, output, NUM_STAGES: active-high resets; bit k is stage k.
- dcm_rst_req, output, 1: active-high re-reset request to the clock generator.
- ready, output, 1: high only when all stages are released.
- fault, output, 1: sticky; lock never achieved within the retry budget.
- loss_cnt, output, 8: saturating count of lock losses after first release.
- state_dbg, output, 3: current state encoding.

## Operation
- locked_in passes through a 2-FF synchronizer. lk = both synchronized bits high.
- States: WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3, REQ=4, FAULT=5.
- **WAIT_LOCK**
  - When lk=1, go to HOLD; clear the hold counter and the retry counter.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1, increment retry and go to REQ. If retry would reach MAX_RETRIES, go to FAULT instead.
- **HOLD**
  - Count consecutive lk=1 cycles.
  - If lk=0, go back to WAIT_LOCK and clear the timeout counter.
  - When count=HOLD_CYCLES-1, go to RELEASE with the gap counter at 0.
- **RELEASE**
  - rst_out[k] deasserts when gap counter = k*STAGE_GAP. Stage 0 releases on the first RELEASE cycle.
  - After stage NUM_STAGES-1 releases, go to RUN.
- **RUN**: ready=1.
- **Lock loss** (lk=0 while in RELEASE or RUN)
  - All rst_out bits reassert the next cycle. ready drops.
  - loss_cnt increments, saturating at 255. Go to WAIT_LOCK with counters cleared.
- **REQ**: dcm_rst_req=1 for exactly REQ_CYCLES cycles, then return to WAIT_LOCK with the timeout counter cleared.
- **FAULT**: terminal. All resets stay asserted and fault=1. Only rst_in exits.
- Counters are sized with $clog2 of their limit. No wrap occurs: every counter is cleared on state entry.

## Timing
- Reset values: state=WAIT_LOCK, rst_out=all ones, dcm_rst_req=0, ready=0, fault=0, loss_cnt=0, all counters 0, synchronizer=0.
- All outputs are registered.
- Edge-to-state latency: a locked_in edge is seen by the FSM 2 cycles later. Lock loss shows on rst_out 3 cycles after the locked_in fall.
- Release timing from a locked_in rise, when lock stays stable:
  - stage 0 at 2+HOLD_CYCLES+1 cycles;
  - stage k at that point plus k*STAGE_GAP;
  - ready in the same cycle as the last stage release.
- Simultaneous events:
  - Lock loss in the same cycle a stage would release: the loss wins, and no stage releases.
  - lk rising in the final timeout cycle: HOLD wins; no request and no retry increment.
- rst_in mid-sequence: next-cycle return to reset values, including fault and loss_cnt.
- lk is ignored during REQ. The pulse is never truncated.

## Structure
- Shared package rst_seq_pkg holds:
  - the state enum and its 3-bit encoding (shared with debug/ILA consumers);
  - the loss_cnt width constant.
- One sub-module: sync2, a generic 2-FF synchronizer parameterized by width, reused for locked_in and elsewhere.

## Test plan
All scenarios use HOLD_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3, TIMEOUT_CYCLES=32, REQ_CYCLES=5, MAX_RETRIES=3.

- **Clean lock**: locked_in=11 from cycle 10 → rst_out bits clear at cycles 21/25/29, ready=1 at cycle 29.
- **Partial lock**: locked_in=01 held → no release; REQ entered at cycle 32 with dcm_rst_req high for exactly 5 cycles.
- **Retry to fault**: locked_in=00 forever → three timeouts, then fault=1 with no third REQ. fault stays high until rst_in.
- **Glitch in HOLD**: locked_in drops for 1 cycle in HOLD → state returns to WAIT_LOCK; release is delayed by the full HOLD restart; loss_cnt stays 0.
- **Loss in RUN**: drop lock in RUN → rst_out=111 three cycles later, loss_cnt=1, ready=0. Relock → re-release. After 300 losses, loss_cnt=255.
- **Reset in RELEASE**: assert rst_in in RELEASE after stage 0 is out → next cycle rst_out=111, state_dbg=0.
